// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the BCD-to-segment decoder.
// Segment order is {a,b,c,d,e,f,g} = m[6:0], active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD codes show nothing rather than a misleading glyph.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter. A carry/borrow enters on cin and leaves
// on cout combinationally, so the whole chain ripples within one cycle.
module bcd_digit (
    input  logic       e,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ld_val,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    logic [3:0] q_q, q_d;

    // This digit rolls over (9->0 up, 0->9 down) when a step reaches it.
    assign cout = cin & (up ? (q_q == 4'd9) : (q_q == 4'd0));
    assign q    = q_q;

    // Next digit value: load wins over counting; illegal load codes become 0.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (ld_val > 4'd9) ? 4'd0 : ld_val;
        end else if (cin) begin
            if (up) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
            else    q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge e) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end

endmodule

// File: rtl/bcd_counter_mux7seg.sv
// Multi-digit BCD up/down counter with a prescaled step and a scanned,
// time-multiplexed 7-segment output. The digit chain lives in bcd_digit;
// this level owns the prescaler, the scan counters and the output registers.
module bcd_counter_mux7seg
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int REFRESH  = 1000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  e,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] s,
    output logic [6:0]            m,
    output logic [N_DIGITS-1:0]   an,
    output logic                  wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (REFRESH  > 1) ? $clog2(REFRESH)  : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0]       P_LAST = PW'(PRESCALE - 1);
    localparam logic [RW-1:0]       R_LAST = RW'(REFRESH - 1);
    localparam logic [IW-1:0]       I_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

    logic [PW-1:0]       pre_q, pre_d;
    logic [RW-1:0]       ref_q, ref_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          m_q, m_d;
    logic                wrap_q, wrap_d;
    logic                step;

    logic [3:0]          digit   [N_DIGITS];
    logic [N_DIGITS:0]   carry;
    logic [N_DIGITS-1:0] zero_above;

    // Step fires on the last prescaler count while enabled.
    assign step     = en & (pre_q == P_LAST);
    assign carry[0] = step;

    genvar k;
    generate
        for (k = 0; k < N_DIGITS; k++) begin : g_digit
            bcd_digit u_digit (
                .e      (e),
                .rst    (rst),
                .load   (load),
                .ld_val (load_val[4*k +: 4]),
                .up     (up),
                .cin    (carry[k]),
                .q      (digit[k]),
                .cout   (carry[k+1])
            );
            assign s[4*k +: 4] = digit[k];
        end
    endgenerate

    // zero_above[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        zero_above = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run           = run & (digit[i] == 4'd0);
            zero_above[i] = run;
        end
    end

    // Next-state for prescaler, wrap flag and display scan.
    always_comb begin
        pre_d  = pre_q;
        ref_d  = ref_q + RW'(1);
        idx_d  = idx_q;
        an_d   = AN_ONE << idx_q;
        m_d    = bcd_to_seg(digit[idx_q]);
        wrap_d = step & ~load & carry[N_DIGITS];

        if (load)    pre_d = '0;
        else if (en) pre_d = step ? '0 : pre_q + PW'(1);

        if (ref_q == R_LAST) begin
            ref_d = '0;
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
        end

        if ((BLANK_LZ != 0) && (idx_q != '0) && zero_above[idx_q])
            m_d = SEG_BLANK;
    end

    // Registers for prescaler, scan counters and the display outputs.
    always_ff @(posedge e) begin
        if (rst) begin
            pre_q  <= '0;
            ref_q  <= '0;
            idx_q  <= '0;
            an_q   <= AN_ONE;
            m_q    <= SEG_0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ref_q  <= ref_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            m_q    <= m_d;
            wrap_q <= wrap_d;
        end
    end

    assign an   = an_q;
    assign m    = m_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// Bench for bcd_counter_mux7seg: two instances share one stimulus stream
// (fast-step/blanking and prescaled/unblanked) and are compared every cycle
// against an integer-valued reference model.
module tb_bcd_counter_mux7seg;

    localparam int ND  = 4;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;

    logic [15:0] s_a, s_b;
    logic [6:0]  m_a, m_b;
    logic [3:0]  an_a, an_b;
    logic        wrap_a, wrap_b;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    bcd_counter_mux7seg #(.N_DIGITS(ND), .PRESCALE(1), .REFRESH(2), .BLANK_LZ(1)) dut_a (
        .e(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .s(s_a), .m(m_a), .an(an_a), .wrap(wrap_a)
    );

    bcd_counter_mux7seg #(.N_DIGITS(ND), .PRESCALE(4), .REFRESH(3), .BLANK_LZ(0)) dut_b (
        .e(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .s(s_b), .m(m_b), .an(an_b), .wrap(wrap_b)
    );

    // ---------------- reference model ----------------
    int         p_cfg [2] = '{1, 4};
    int         r_cfg [2] = '{2, 3};
    int         b_cfg [2] = '{1, 0};
    logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int         mv [2];   // count as a plain integer 0..MOD-1
    int         mp [2];   // cycles since last step
    int         mi [2];   // digit being scanned
    int         mr [2];   // cycles spent on that digit
    logic [3:0] man [2];
    logic [6:0] mm [2];
    bit         mw [2];
    bit         model_valid = 0;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int v = 0;
        for (int i = 0; i < ND; i++) begin
            int d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    task automatic model_edge(input int j);
        if (rst) begin
            mv[j] = 0; mp[j] = 0; mi[j] = 0; mr[j] = 0;
            man[j] = 4'b0001; mm[j] = 7'h7E; mw[j] = 0;
            return;
        end
        // display shows the digit under scan, using the count before this edge
        begin
            int d = (mv[j] / pow10(mi[j])) % 10;
            man[j] = 4'(1 << mi[j]);
            if (b_cfg[j] != 0 && mi[j] > 0 && mv[j] < pow10(mi[j])) mm[j] = 7'h00;
            else                                                    mm[j] = seg_tab[d];
        end
        mr[j] = mr[j] + 1;
        if (mr[j] == r_cfg[j]) begin
            mr[j] = 0;
            mi[j] = (mi[j] + 1) % ND;
        end
        mw[j] = 0;
        if (load) begin
            mv[j] = from_load(load_val);
            mp[j] = 0;
        end else if (en) begin
            if (mp[j] == p_cfg[j] - 1) begin
                mp[j] = 0;
                if (up) begin
                    mw[j] = (mv[j] == MOD - 1);
                    mv[j] = (mv[j] + 1) % MOD;
                end else begin
                    mw[j] = (mv[j] == 0);
                    mv[j] = (mv[j] + MOD - 1) % MOD;
                end
            end else begin
                mp[j] = mp[j] + 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a.s",    32'(s_a),    32'(to_bcd(mv[0])));
        check("a.an",   32'(an_a),   32'(man[0]));
        check("a.m",    32'(m_a),    32'(mm[0]));
        check("a.wrap", 32'(wrap_a), 32'(mw[0]));
        check("b.s",    32'(s_b),    32'(to_bcd(mv[1])));
        check("b.an",   32'(an_b),   32'(man[1]));
        check("b.m",    32'(m_b),    32'(mm[1]));
        check("b.wrap", 32'(wrap_b), 32'(mw[1]));
    endtask

    // ---------------- driver ----------------
    // Inputs change just after a negedge; the model advances at the posedge
    // and both DUTs are compared at the following negedge.
    task automatic cyc(input logic r, input logic l, input logic [15:0] lv,
                       input logic e_in, input logic u);
        rst = r; load = l; load_val = lv; en = e_in; up = u;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        if (r) model_valid = 1;
        @(negedge clk);
        if (model_valid) compare_all();
    endtask

    task automatic run(input int n, input logic e_in, input logic u);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, e_in, u);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        @(negedge clk);

        // reset, then idle with en=0
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check("rst.s",    32'(s_a),    32'h0000);
        check("rst.an",   32'(an_a),   32'h1);
        check("rst.m",    32'(m_a),    32'h7E);
        check("rst.wrap", 32'(wrap_a), 32'h0);
        run(3, 1'b0, 1'b1);
        check("idle.s", 32'(s_a), 32'h0000);

        // up across the wrap
        cyc(1'b0, 1'b1, 16'h9998, 1'b1, 1'b1);
        run(1, 1'b1, 1'b1);
        check("up.9999", 32'(s_a), 32'h9999);
        run(1, 1'b1, 1'b1);
        check("up.0000", 32'(s_a), 32'h0000);
        check("up.wrap", 32'(wrap_a), 32'h1);
        run(1, 1'b1, 1'b1);
        check("up.0001", 32'(s_a), 32'h0001);
        check("up.nowrap", 32'(wrap_a), 32'h0);

        // down with borrow, then down wrap
        cyc(1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0);
        check("dn.0998", 32'(s_a), 32'h0998);
        cyc(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0);
        check("dn.9999", 32'(s_a), 32'h9999);
        check("dn.wrap", 32'(wrap_a), 32'h1);

        // prescaled count with an enable gap, load over step, rst over load
        cyc(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        run(9, 1'b1, 1'b1);
        run(2, 1'b0, 1'b1);
        run(7, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 16'h4321, 1'b1, 1'b1);
        check("ld.over.step", 32'(s_a), 32'h4321);
        cyc(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
        check("rst.over.load", 32'(s_a), 32'h0000);

        // scan with leading-zero blanking
        cyc(1'b0, 1'b1, 16'h0042, 1'b0, 1'b1);
        run(16, 1'b0, 1'b1);

        // illegal BCD load, then counting from it
        cyc(1'b0, 1'b1, 16'hA3F5, 1'b0, 1'b1);
        check("ld.illegal", 32'(s_a), 32'h0305);
        run(6, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic r_in, l_in, e_in, u_in;
            r_in = ($urandom_range(0, 99) == 0);
            l_in = ($urandom_range(0, 19) == 0);
            e_in = ($urandom_range(0, 3) != 0);
            u_in = ($urandom_range(0, 1) == 1);
            cyc(r_in, l_in, 16'($urandom), e_in, u_in);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
